// File: rtl/tick_pwm_breath.sv
// tick_pwm_breath: breathing-LED PWM driver stepped by tick rising edges.
// Optional BREATH_GAMMA_EN: quadratic brightness curve with a registered cmp.
module tick_pwm_breath #(
  parameter int PWM_BITS   = 8,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 0
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                tick_in,
  input  logic                en,
  output logic                led_out,
  output logic [PWM_BITS-1:0] duty,
  output logic                dir,
  output logic                period_done
);

  localparam int DUTY_MAX = (1 << PWM_BITS) - 1;
  localparam int HW = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);

  localparam logic [PWM_BITS-1:0] DMAX = PWM_BITS'(DUTY_MAX);
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'(DUTY_MAX - 1);
  localparam logic [PWM_BITS:0] DMAX_W = (PWM_BITS + 1)'(DUTY_MAX);
  localparam logic [PWM_BITS:0] STEP_W = (PWM_BITS + 1)'(STEP);
  localparam logic [HW-1:0] HOLD_END = HW'(HOLD_TICKS);

  typedef enum logic [2:0] {
    IDLE,
    RISE,
    HOLD_HI,
    FALL,
    HOLD_LO
  } state_t;

  state_t state_q, state_d;

  logic [PWM_BITS-1:0] shadow_q, shadow_d;
  logic [PWM_BITS-1:0] rise_val, fall_val;
  logic [PWM_BITS-1:0] pwm_cnt, cmp;
  logic [PWM_BITS:0]   sum;
  logic [HW-1:0]       hold_q, hold_d, hold_nxt;
  logic                dir_d, pd_d;
  logic                tick_d, tick_rise;

  assign tick_rise = tick_in & ~tick_d;
  assign sum       = {1'b0, shadow_q} + STEP_W;
  assign rise_val  = (sum >= DMAX_W) ? DMAX : sum[PWM_BITS-1:0];
  assign fall_val  = ({1'b0, shadow_q} <= STEP_W) ? '0
                   : shadow_q - STEP_W[PWM_BITS-1:0];
  assign hold_nxt  = hold_q + HW'(1);

  // Delay tick_in by one cycle so a held level yields a single rising edge
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) tick_d <= 1'b0;
    else         tick_d <= tick_in;
  end

  // Sequencer: ramp-up / hold / ramp-down / hold, one step per tick edge
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    hold_d   = hold_q;
    dir_d    = dir;
    pd_d     = 1'b0;
    if (!en) begin
      state_d  = IDLE;
      shadow_d = '0;
      hold_d   = '0;
      dir_d    = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = RISE;
          shadow_d = '0;
          dir_d    = 1'b1;
        end
        RISE: if (tick_rise) begin
          shadow_d = rise_val;
          if (rise_val == DMAX) begin
            hold_d = '0;
            if (HOLD_TICKS == 0) begin
              state_d = FALL;
              dir_d   = 1'b0;
            end else begin
              state_d = HOLD_HI;
            end
          end
        end
        HOLD_HI: if (tick_rise) begin
          hold_d = hold_nxt;
          if (hold_nxt == HOLD_END) begin
            state_d = FALL;
            dir_d   = 1'b0;
            hold_d  = '0;
          end
        end
        FALL: if (tick_rise) begin
          shadow_d = fall_val;
          if (fall_val == '0) begin
            hold_d = '0;
            if (HOLD_TICKS == 0) begin
              state_d = RISE;
              dir_d   = 1'b1;
              pd_d    = 1'b1;
            end else begin
              state_d = HOLD_LO;
            end
          end
        end
        HOLD_LO: if (tick_rise) begin
          hold_d = hold_nxt;
          if (hold_nxt == HOLD_END) begin
            state_d = RISE;
            dir_d   = 1'b1;
            pd_d    = 1'b1;
            hold_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      hold_q      <= '0;
      dir         <= 1'b1;
      period_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      hold_q      <= hold_d;
      dir         <= dir_d;
      period_done <= pd_d;
    end
  end

`ifdef BREATH_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;

  assign sq = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};

  // Registered squared duty keeps the multiplier off the compare path
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)  cmp <= '0;
    else if (!en) cmp <= '0;
    else          cmp <= sq[2*PWM_BITS-1:PWM_BITS];
  end
`else
  assign cmp = duty;
`endif

  // Free-running PWM; active duty reloads from shadow only at period end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pwm_cnt <= '0;
      duty    <= '0;
      led_out <= 1'b0;
    end else if (!en) begin
      pwm_cnt <= '0;
      duty    <= '0;
      led_out <= 1'b0;
    end else begin
      if (pwm_cnt == CNT_LAST) begin
        pwm_cnt <= '0;
        duty    <= shadow_q;
      end else begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
      led_out <= (pwm_cnt < cmp);
    end
  end

endmodule

// File: tb/tb_tick_pwm_breath.sv
// tb_tick_pwm_breath: randomized tick stimulus against an arithmetic model
// of the breathing sequence; three DUT configurations share the inputs.
module tb_tick_pwm_breath;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic tick_in = 1'b0;
  logic en      = 1'b0;

  logic       led_m, dir_m, pd_m;
  logic [3:0] duty_m;
  logic       led_h, dir_h, pd_h;
  logic [3:0] duty_h;
  logic       led_s, dir_s, pd_s;
  logic [3:0] duty_s;

  int n_checks = 0;
  int n_fail   = 0;

  int pdc_m = 0, pdc_h = 0, pdc_s = 0;
  int wide_m = 0, wide_h = 0, wide_s = 0;
  logic pd_m_q = 1'b0, pd_h_q = 1'b0, pd_s_q = 1'b0;

  always #5 sys_clk = ~sys_clk;

  tick_pwm_breath #(.PWM_BITS(4), .STEP(1), .HOLD_TICKS(2)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tick_in(tick_in), .en(en),
    .led_out(led_m), .duty(duty_m), .dir(dir_m), .period_done(pd_m)
  );

  tick_pwm_breath #(.PWM_BITS(4), .STEP(1), .HOLD_TICKS(0)) dut_h0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tick_in(tick_in), .en(en),
    .led_out(led_h), .duty(duty_h), .dir(dir_h), .period_done(pd_h)
  );

  tick_pwm_breath #(.PWM_BITS(4), .STEP(4), .HOLD_TICKS(0)) dut_s4 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tick_in(tick_in), .en(en),
    .led_out(led_s), .duty(duty_s), .dir(dir_s), .period_done(pd_s)
  );

  // period_done pulse counters and pulse-width watch
  always @(negedge sys_clk) begin
    if (pd_m) begin
      pdc_m <= pdc_m + 1;
      if (pd_m_q) wide_m <= wide_m + 1;
    end
    if (pd_h) begin
      pdc_h <= pdc_h + 1;
      if (pd_h_q) wide_h <= wide_h + 1;
    end
    if (pd_s) begin
      pdc_s <= pdc_s + 1;
      if (pd_s_q) wide_s <= wide_s + 1;
    end
    pd_m_q <= pd_m;
    pd_h_q <= pd_h;
    pd_s_q <= pd_s;
  end

  // Applied duty after k ticks since enable
  function automatic int model_duty(int k, int s, int h);
    int r, l, p, v;
    r = (15 + s - 1) / s;
    l = 2 * (r + h);
    p = k % l;
    if (p <= r) begin
      v = p * s;
      return (v > 15) ? 15 : v;
    end
    if (p <= r + h) return 15;
    if (p <= 2 * r + h) begin
      v = 15 - (p - r - h) * s;
      return (v < 0) ? 0 : v;
    end
    return 0;
  endfunction

  function automatic int model_dir(int k, int s, int h);
    int r;
    r = (15 + s - 1) / s;
    return ((k % (2 * (r + h))) >= r + h) ? 0 : 1;
  endfunction

  function automatic int model_pd(int k, int s, int h);
    int r;
    r = (15 + s - 1) / s;
    return k / (2 * (r + h));
  endfunction

  function automatic int model_cmp(int d);
`ifdef BREATH_GAMMA_EN
    return (d * d) >> 4;
`else
    return d;
`endif
  endfunction

  function automatic int model_lat();
`ifdef BREATH_GAMMA_EN
    return 2;
`else
    return 1;
`endif
  endfunction

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    tick_in = 1'b0;
    en      = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic start();
    en = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic tick_pulse(input int width, input int gap);
    @(negedge sys_clk);
    tick_in = 1'b1;
    repeat (width) @(negedge sys_clk);
    tick_in = 1'b0;
    repeat (gap) @(negedge sys_clk);
  endtask

  task automatic rand_tick();
    tick_pulse($urandom_range(1, 4), $urandom_range(20, 30));
  endtask

  task automatic count_high(output int n);
    n = 0;
    repeat (15) begin
      @(negedge sys_clk);
      if (led_m) n++;
    end
  endtask

  task automatic test_reset();
    int w;
    @(negedge sys_clk);
    n_checks += 4;
    if (led_m !== 1'b0) begin
      n_fail++; $display("FAIL rst_led: got %b want 0", led_m);
    end
    if (duty_m !== 4'd0) begin
      n_fail++; $display("FAIL rst_duty: got %0d want 0", duty_m);
    end
    if (dir_m !== 1'b1) begin
      n_fail++; $display("FAIL rst_dir: got %b want 1", dir_m);
    end
    if (pd_m !== 1'b0) begin
      n_fail++; $display("FAIL rst_pd: got %b want 0", pd_m);
    end
    do_reset();
    start();
    for (int k = 1; k <= 7; k++) rand_tick();
    n_checks++;
    if (int'(duty_m) !== 7) begin
      n_fail++; $display("FAIL pre_rst_duty: got %0d want 7", duty_m);
    end
    w = 0;
    while (led_m !== 1'b1 && w < 20) begin
      @(negedge sys_clk);
      w++;
    end
    n_checks++;
    if (led_m !== 1'b1) begin
      n_fail++; $display("FAIL pre_rst_led: got %b want 1", led_m);
    end
    #1 sys_rst = 1'b1;
    #1;
    n_checks += 4;
    if (led_m !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_led: got %b want 0", led_m);
    end
    if (duty_m !== 4'd0) begin
      n_fail++; $display("FAIL async_rst_duty: got %0d want 0", duty_m);
    end
    if (pd_m !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_pd: got %b want 0", pd_m);
    end
    if (dir_m !== 1'b1) begin
      n_fail++; $display("FAIL async_rst_dir: got %b want 1", dir_m);
    end
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_ramp_up();
    int n;
    do_reset();
    start();
    for (int k = 1; k <= 15; k++) begin
      rand_tick();
      n_checks += 2;
      if (int'(duty_m) !== model_duty(k, 1, 2)) begin
        n_fail++;
        $display("FAIL ramp_duty[%0d]: got %0d want %0d",
                 k, duty_m, model_duty(k, 1, 2));
      end
      if (int'(dir_m) !== model_dir(k, 1, 2)) begin
        n_fail++;
        $display("FAIL ramp_dir[%0d]: got %b want %0d",
                 k, dir_m, model_dir(k, 1, 2));
      end
    end
    count_high(n);
    n_checks++;
    if (n !== model_cmp(15)) begin
      n_fail++;
      $display("FAIL full_on_high: got %0d want %0d", n, model_cmp(15));
    end
  endtask

  task automatic test_duty_accuracy();
    int m, n;
    for (int t = 0; t < 3; t++) begin
      do_reset();
      start();
      m = (t == 0) ? 5 : $urandom_range(1, 14);
      for (int k = 1; k <= m; k++) rand_tick();
      n_checks += 2;
      if (int'(duty_m) !== m) begin
        n_fail++; $display("FAIL park_duty: got %0d want %0d", duty_m, m);
      end
      count_high(n);
      if (n !== model_cmp(m)) begin
        n_fail++;
        $display("FAIL park_high[d=%0d]: got %0d want %0d",
                 m, n, model_cmp(m));
      end
    end
  endtask

  task automatic test_full_cycle();
    int bm, bh, wm, wh;
    do_reset();
    start();
    bm = pdc_m;
    bh = pdc_h;
    wm = wide_m;
    wh = wide_h;
    for (int k = 1; k <= 34; k++) begin
      rand_tick();
      n_checks += 4;
      if (int'(duty_m) !== model_duty(k, 1, 2)) begin
        n_fail++;
        $display("FAIL cyc_duty[%0d]: got %0d want %0d",
                 k, duty_m, model_duty(k, 1, 2));
      end
      if (int'(dir_m) !== model_dir(k, 1, 2)) begin
        n_fail++;
        $display("FAIL cyc_dir[%0d]: got %b want %0d",
                 k, dir_m, model_dir(k, 1, 2));
      end
      if (pdc_m - bm !== model_pd(k, 1, 2)) begin
        n_fail++;
        $display("FAIL cyc_pd_h2[%0d]: got %0d want %0d",
                 k, pdc_m - bm, model_pd(k, 1, 2));
      end
      if (pdc_h - bh !== model_pd(k, 1, 0)) begin
        n_fail++;
        $display("FAIL cyc_pd_h0[%0d]: got %0d want %0d",
                 k, pdc_h - bh, model_pd(k, 1, 0));
      end
    end
    n_checks += 2;
    if (wide_m !== wm) begin
      n_fail++; $display("FAIL pd_width_h2: got %0d wide want 0", wide_m - wm);
    end
    if (wide_h !== wh) begin
      n_fail++; $display("FAIL pd_width_h0: got %0d wide want 0", wide_h - wh);
    end
  endtask

  task automatic test_level_tick();
    int bs;
    do_reset();
    start();
    bs = pdc_s;
    @(negedge sys_clk);
    tick_in = 1'b1;
    repeat (100) @(negedge sys_clk);
    tick_in = 1'b0;
    repeat (25) @(negedge sys_clk);
    n_checks += 2;
    if (duty_m !== 4'd1) begin
      n_fail++; $display("FAIL level_duty: got %0d want 1", duty_m);
    end
    if (duty_s !== 4'd4) begin
      n_fail++; $display("FAIL level_duty_s4: got %0d want 4", duty_s);
    end
    for (int k = 2; k <= 8; k++) begin
      rand_tick();
      n_checks += 3;
      if (int'(duty_s) !== model_duty(k, 4, 0)) begin
        n_fail++;
        $display("FAIL s4_duty[%0d]: got %0d want %0d",
                 k, duty_s, model_duty(k, 4, 0));
      end
      if (int'(dir_s) !== model_dir(k, 4, 0)) begin
        n_fail++;
        $display("FAIL s4_dir[%0d]: got %b want %0d",
                 k, dir_s, model_dir(k, 4, 0));
      end
      if (pdc_s - bs !== model_pd(k, 4, 0)) begin
        n_fail++;
        $display("FAIL s4_pd[%0d]: got %0d want %0d",
                 k, pdc_s - bs, model_pd(k, 4, 0));
      end
    end
  endtask

  task automatic test_disable();
    int n;
    do_reset();
    start();
    for (int k = 1; k <= 23; k++) rand_tick();
    n_checks += 2;
    if (duty_m !== 4'd9) begin
      n_fail++; $display("FAIL dis_pre_duty: got %0d want 9", duty_m);
    end
    if (dir_m !== 1'b0) begin
      n_fail++; $display("FAIL dis_pre_dir: got %b want 0", dir_m);
    end
    en = 1'b0;
    @(negedge sys_clk);
    n_checks += 3;
    if (led_m !== 1'b0) begin
      n_fail++; $display("FAIL dis_led: got %b want 0", led_m);
    end
    if (duty_m !== 4'd0) begin
      n_fail++; $display("FAIL dis_duty: got %0d want 0", duty_m);
    end
    if (dir_m !== 1'b1) begin
      n_fail++; $display("FAIL dis_dir: got %b want 1", dir_m);
    end
    repeat (3) tick_pulse(2, 20);
    count_high(n);
    n_checks += 2;
    if (n !== 0) begin
      n_fail++; $display("FAIL dis_idle_high: got %0d want 0", n);
    end
    if (duty_m !== 4'd0) begin
      n_fail++; $display("FAIL dis_idle_duty: got %0d want 0", duty_m);
    end
    start();
    rand_tick();
    n_checks += 2;
    if (duty_m !== 4'd1) begin
      n_fail++; $display("FAIL reen_duty: got %0d want 1", duty_m);
    end
    if (dir_m !== 1'b1) begin
      n_fail++; $display("FAIL reen_dir: got %b want 1", dir_m);
    end
  endtask

  task automatic test_shadow_align();
    int m, cyc, prev, lat, c;
    logic seen;
    logic [15:0] leds;
    logic [14:0] got, exp;
    lat = model_lat();
    for (int t = 0; t < 3; t++) begin
      do_reset();
      start();
      m = $urandom_range(2, 13);
      for (int k = 1; k <= m; k++) rand_tick();
      prev = int'(duty_m);
      @(negedge sys_clk);
      tick_in = 1'b1;
      @(negedge sys_clk);
      tick_in = 1'b0;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
        if (int'(duty_m) != prev) seen = 1'b1;
        else begin
          @(negedge sys_clk);
          cyc++;
        end
      end
      n_checks += 2;
      if (!seen || cyc > 15) begin
        n_fail++;
        $display("FAIL load_delay: got %0d cycles want <=15", cyc);
      end
      if (int'(duty_m) !== m + 1) begin
        n_fail++;
        $display("FAIL load_duty: got %0d want %0d", duty_m, m + 1);
      end
      for (int j = 1; j <= 16; j++) begin
        @(negedge sys_clk);
        leds[j-1] = led_m;
      end
      c = model_cmp(m + 1);
      for (int j = lat; j < lat + 15; j++) begin
        got[j-lat] = leds[j-1];
        exp[j-lat] = (((j - 1) % 15) < c);
      end
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL load_phase[d=%0d]: got %b want %b", m + 1, got, exp);
      end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ramp_up();
    test_duty_accuracy();
    test_full_cycle();
    test_level_tick();
    test_disable();
    test_shadow_align();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_pwm_breath.md
Name: tick_pwm_breath

Overview:
Breathing-LED driver that consumes the periodic flag produced by the system tick counter (50 MHz domain). Each tick rising edge steps a PWM duty value through a ramp-up / hold / ramp-down / hold cycle. The LED is driven from a free-running PWM comparator. Duty updates are shadowed to PWM period boundaries so the LED output never glitches.

Parameters:
PWM_BITS, 8, width of duty and PWM counter; DUTY_MAX = 2^PWM_BITS - 1
STEP, 1, duty increment/decrement per tick; must satisfy 1 <= STEP <= DUTY_MAX
HOLD_TICKS, 0, ticks spent at each extreme (0 = reverse immediately)

Ports:
sys_clk  input  1  system clock, 50 MHz
sys_rst  input  1  asynchronous, active-high reset
tick_in  input  1  flag from tick counter; pulse or level, rising edge used
en  input  1  1 = run, 0 = LED off and sequencer parked
led_out  output  1  PWM LED drive, registered
duty  output  PWM_BITS  active (applied) duty value
dir  output  1  1 = rising/high half of cycle, 0 = falling/low half
period_done  output  1  one-cycle pulse at the end of each full breath cycle

Behaviour:
- Reset (async, sys_rst=1): led_out=0, duty=0, dir=1, period_done=0, shadow duty=0, pwm_cnt=0, hold_cnt=0, tick_d=0, state=IDLE.
- Tick detect: tick_d <= tick_in; tick_rise = tick_in & ~tick_d. A level held high for N cycles counts as one tick.
- PWM: pwm_cnt counts 0..DUTY_MAX-1 and wraps (period = DUTY_MAX cycles). led_out <= (pwm_cnt < cmp), where cmp is derived from the active duty. Output latency is 1 cycle. Active duty 0 -> always off; DUTY_MAX -> always on.
- Shadowing: the sequencer writes the shadow duty. Active duty loads from the shadow only on the cycle pwm_cnt == DUTY_MAX-1, so the new value takes effect from pwm_cnt=0.
- FSM, advancing only on tick_rise while en=1:
  - IDLE: on en=1 (no tick needed), shadow=0, go to RISE, dir=1.
  - RISE: shadow = min(shadow+STEP, DUTY_MAX), computed at PWM_BITS+1 width with no wrap. On reaching DUTY_MAX, go to HOLD_HI with hold_cnt=0. If HOLD_TICKS=0, go straight to FALL.
  - HOLD_HI: hold_cnt++. When hold_cnt reaches HOLD_TICKS, go to FALL, dir=0.
  - FALL: shadow = max(shadow-STEP, 0), saturating. On reaching 0, go to HOLD_LO. If HOLD_TICKS=0, go to RISE and pulse period_done.
  - HOLD_LO: hold_cnt++. When hold_cnt reaches HOLD_TICKS, go to RISE, dir=1, and pulse period_done for 1 cycle.
- Full cycle length: 2*(ceil(DUTY_MAX/STEP) + HOLD_TICKS) ticks.
- en=0, any state, effective next clock: state=IDLE, shadow=0, active duty=0, pwm_cnt=0, led_out=0, hold_cnt=0, dir=1. Ticks are ignored. Re-enable restarts from duty 0.
- A tick coinciding with en falling is ignored. A tick coinciding with the shadow-load cycle is applied at the following PWM wrap.
- Reset mid-cycle: all outputs return to reset values immediately, with no completion of the current PWM period.

Optional Feature:
BREATH_GAMMA_EN
- Defined: cmp = (duty*duty) >> PWM_BITS, computed at 2*PWM_BITS width. This gives a perceptual (quadratic) brightness curve. It adds 1 register stage on cmp, so led_out latency from an active-duty change is 2 cycles.
- Undefined: cmp = duty (linear), latency 1 cycle.
- FSM, duty port, and period_done are identical in both builds.

Test Plan:
- Bench config for all scenarios: PWM_BITS=4 (DUTY_MAX=15), STEP=1, HOLD_TICKS=2, unless noted.
- Reset: pulse sys_rst asynchronously mid-RISE at duty=7 -> led_out, duty and period_done read 0 before the next clock edge; dir=1.
- Ramp up: en=1, 15 tick pulses -> duty reads 1..15 in turn, each applied at the next pwm_cnt=0. At duty=15, led_out stays high continuously for a full 15-cycle period.
- Duty accuracy: park at duty=5 (stop ticks) -> led_out high exactly 5 of every 15 cycles. Same test with BREATH_GAMMA_EN -> cmp=(25>>4)=1, high 1 of 15.
- Full cycle: continuous ticks from enable -> period_done pulses once, 1 cycle wide, on tick 34 (15+2+15+2). With HOLD_TICKS=0 it pulses on tick 30.
- Level tick and saturation: tick_in held high for 100 cycles -> duty advances by exactly 1. With STEP=4, duty sequence is 4, 8, 12, 15, then falling 11, 7, 3, 0.
- Disable: en=0 at duty=9 during FALL -> next clock led_out=0, duty=0, dir=1. Re-enable -> RISE from 0, first tick gives duty 1.
